// File: rtl/jump_timing_fsm.sv
// Frame-rate game controller: keycode-driven IDLE/PLAY/STOP FSM with a
// platform-load strobe, plus a two-stage jump/acceleration frame timer.
//
// Ports:
//   frame_clk   - frame clock, all state moves on its rising edge
//   Reset       - asynchronous, active-high reset
//   keycode     - current keycode (0 = no key)
//   jump_reset  - synchronous clear of both counters (wins over enable)
//   jump_enable - stage-1 count enable
//   frame_cnt   - stage-1 frame counter
//   acc_cnt     - stage-2 acceleration counter, stepped while frame_cnt MSB set
//   outstate    - 000 IDLE, 001 PLAY, 010 STOP
//   loadplat    - high for the first PLAY frame only
module jump_timing_fsm #(
  parameter int unsigned CNT_WIDTH   = 7,
  parameter int unsigned ACC_WIDTH   = 2,
  parameter logic [7:0]  START_KEY   = 8'd40,
  parameter logic [7:0]  STOP_KEY    = 8'd41,
  parameter logic [7:0]  RESTART_KEY = 8'd21
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic                 jump_reset,
  input  logic                 jump_enable,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [ACC_WIDTH-1:0] acc_cnt,
  output logic [2:0]           outstate,
  output logic                 loadplat
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    PLAY = 3'b001,
    STOP = 3'b010
  } stateT;

  stateT      state;
  stateT      stateNext;
  logic       loadNext;
  logic [7:0] prevKey;
  logic       startEv;
  logic       stopEv;
  logic       restartEv;

  // A held key fires once; it re-arms when the keycode changes.
  assign startEv   = (keycode == START_KEY)
                  && (prevKey != START_KEY);
  assign stopEv    = (keycode == STOP_KEY)
                  && (prevKey != STOP_KEY);
  assign restartEv = (keycode == RESTART_KEY)
                  && (prevKey != RESTART_KEY);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      loadplat <= 1'b0;
      prevKey  <= 8'd0;
    end else begin
      state    <= stateNext;
      loadplat <= loadNext;
      prevKey  <= keycode;
    end
  end

  always_comb begin
    stateNext = IDLE;
    loadNext  = 1'b0;
    case (state)
      IDLE: stateNext = startEv   ? PLAY : IDLE;
      PLAY: stateNext = stopEv    ? STOP : PLAY;
      STOP: stateNext = restartEv ? IDLE : STOP;
      default: stateNext = IDLE;
    endcase
    // Strobe lands on the same edge that first loads PLAY.
    loadNext = (stateNext == PLAY) && (state != PLAY);
  end

  assign outstate = state;

  // Stage 2 is level-enabled by the registered stage-1 MSB.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= '0;
      acc_cnt   <= '0;
    end else begin
      if (jump_reset)
        frame_cnt <= '0;
      else if (jump_enable)
        frame_cnt <= frame_cnt + 1'b1;

      if (jump_reset)
        acc_cnt <= '0;
      else if (frame_cnt[CNT_WIDTH-1])
        acc_cnt <= acc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_timing_fsm.sv
// Self-checking bench for jump_timing_fsm.
// Behavioural model pushes expectations; tasks pop and compare.
module tb_jump_timing_fsm;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       jump_reset;
  logic       jump_enable;
  logic [6:0] frame_cnt;
  logic [1:0] acc_cnt;
  logic [2:0] outstate;
  logic       loadplat;

  jump_timing_fsm dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .jump_reset (jump_reset),
    .jump_enable(jump_enable),
    .frame_cnt  (frame_cnt),
    .acc_cnt    (acc_cnt),
    .outstate   (outstate),
    .loadplat   (loadplat)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [6:0] fc;
    logic [1:0] acc;
    logic [2:0] st;
    logic       lp;
  } expT;

  expT sb[$];
  expT e;
  expT got;
  int  nChecks = 0;
  int  nFails  = 0;

  logic [6:0] mFc;
  logic [1:0] mAcc;
  logic [2:0] mSt;
  logic       mLp;
  logic [7:0] mPrev;

  task automatic modelReset();
    mFc   = '0;
    mAcc  = '0;
    mSt   = 3'b000;
    mLp   = 1'b0;
    mPrev = 8'd0;
    sb.delete();
  endtask

  task automatic drive(input logic [7:0] k,
                       input logic jr,
                       input logic je);
    logic [2:0] nSt;
    logic [6:0] nFc;
    logic [1:0] nAcc;
    nSt = mSt;
    if (mSt == 3'b000 && k == 8'd40 && mPrev != 8'd40)
      nSt = 3'b001;
    else if (mSt == 3'b001 && k == 8'd41 && mPrev != 8'd41)
      nSt = 3'b010;
    else if (mSt == 3'b010 && k == 8'd21 && mPrev != 8'd21)
      nSt = 3'b000;
    nFc  = jr ? 7'd0 : (je ? 7'((mFc + 1) % 128) : mFc);
    nAcc = jr ? 2'd0 : (mFc >= 7'd64 ? 2'((mAcc + 1) % 4) : mAcc);
    mLp   = (nSt == 3'b001) && (mSt != 3'b001);
    mSt   = nSt;
    mFc   = nFc;
    mAcc  = nAcc;
    mPrev = k;
    sb.push_back('{fc: mFc, acc: mAcc, st: mSt, lp: mLp});
    keycode     = k;
    jump_reset  = jr;
    jump_enable = je;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    keycode = 8'd0;
    jump_reset = 1'b0;
    jump_enable = 1'b0;
    #1 Reset = 1'b1;
    #2;
    got = {frame_cnt, acc_cnt, outstate, loadplat};
    nChecks++;
    if (got !== 13'd0) begin
      nFails++;
      $display("FAIL reset_async got=%h want=0", got);
    end
    @(posedge frame_clk);
    #1;
    got = {frame_cnt, acc_cnt, outstate, loadplat};
    nChecks++;
    if (got !== 13'd0) begin
      nFails++;
      $display("FAIL reset_held got=%h want=0", got);
    end
    Reset = 1'b0;
    modelReset();
  endtask

  task automatic test_mid_reset();
    drive(8'd40, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      drive(8'd0, 1'b0, 1'b1);
      e = sb.pop_front();
      if (i == 0) e = sb.pop_front();
    end
    nChecks++;
    if (frame_cnt !== 7'd50 || outstate !== 3'b001) begin
      nFails++;
      $display("FAIL pre_reset fc=%0d st=%b want 50/001",
               frame_cnt, outstate);
    end
    #2 Reset = 1'b1;
    #1;
    got = {frame_cnt, acc_cnt, outstate, loadplat};
    nChecks++;
    if (got !== 13'd0) begin
      nFails++;
      $display("FAIL mid_reset got=%h want=0", got);
    end
    Reset = 1'b0;
    modelReset();
  endtask

  task automatic test_count();
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      drive(8'd0, 1'b0, 1'b1);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      if (got !== e) bad++;
    end
    nChecks++;
    if (frame_cnt !== 7'd64 || acc_cnt !== 2'd0) begin
      nFails++;
      $display("FAIL count64 fc=%0d acc=%0d want 64/0",
               frame_cnt, acc_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      drive(8'd0, 1'b0, 1'b1);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      if (got !== e) bad++;
    end
    nChecks++;
    if (frame_cnt !== 7'd68 || acc_cnt !== 2'd0) begin
      nFails++;
      $display("FAIL count68 fc=%0d acc=%0d want 68/0",
               frame_cnt, acc_cnt);
    end
    for (int i = 0; i < 59; i++) begin
      drive(8'd0, 1'b0, 1'b1);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      if (got !== e) bad++;
    end
    nChecks++;
    if (frame_cnt !== 7'd127 || acc_cnt !== 2'd3) begin
      nFails++;
      $display("FAIL count127 fc=%0d acc=%0d want 127/3",
               frame_cnt, acc_cnt);
    end
    drive(8'd0, 1'b0, 1'b1);
    e = sb.pop_front();
    nChecks++;
    if (frame_cnt !== 7'd0 || acc_cnt !== 2'd0) begin
      nFails++;
      $display("FAIL wrap fc=%0d acc=%0d want 0/0",
               frame_cnt, acc_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      drive(8'd0, 1'b0, 1'b0);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      if (got !== e) bad++;
    end
    nChecks++;
    if (bad != 0) begin
      nFails++;
      $display("FAIL count_model %0d frames differ, want 0", bad);
    end
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 90; i++) begin
      drive(8'd0, 1'b0, 1'b1);
      e = sb.pop_front();
    end
    nChecks++;
    if (frame_cnt !== 7'd90 || acc_cnt !== 2'd2) begin
      nFails++;
      $display("FAIL pre_clear fc=%0d acc=%0d want 90/2",
               frame_cnt, acc_cnt);
    end
    drive(8'd0, 1'b1, 1'b1);
    e = sb.pop_front();
    nChecks++;
    if (frame_cnt !== 7'd0 || acc_cnt !== 2'd0) begin
      nFails++;
      $display("FAIL clear_wins fc=%0d acc=%0d want 0/0",
               frame_cnt, acc_cnt);
    end
  endtask

  task automatic test_start();
    drive(8'd55, 1'b0, 1'b0);
    e = sb.pop_front();
    got = {frame_cnt, acc_cnt, outstate, loadplat};
    nChecks++;
    if (got !== e || outstate !== 3'b000) begin
      nFails++;
      $display("FAIL ignore_key got=%h want=%h", got, e);
    end
    for (int i = 0; i < 5; i++) begin
      drive(8'd40, 1'b0, 1'b0);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      nChecks++;
      if (got !== e || outstate !== 3'b001
          || loadplat !== (i == 0)) begin
        nFails++;
        $display("FAIL start_held[%0d] st=%b lp=%b want 001/%0d",
                 i, outstate, loadplat, (i == 0));
      end
    end
  endtask

  task automatic test_play_stop();
    logic [7:0] keys [4];
    logic [2:0] want [4];
    keys = '{8'd41, 8'd40, 8'd0, 8'd21};
    want = '{3'b010, 3'b010, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) begin
      drive(keys[i], 1'b0, 1'b0);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      nChecks++;
      if (got !== e || outstate !== want[i] || loadplat !== 1'b0) begin
        nFails++;
        $display("FAIL play_stop[%0d] st=%b lp=%b want %b/0",
                 i, outstate, loadplat, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int trans = 0;
    logic [2:0] last;
    drive(8'd40, 1'b0, 1'b0);
    e = sb.pop_front();
    drive(8'd41, 1'b0, 1'b0);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(8'd40, 1'b0, 1'b0);
      e = sb.pop_front();
    end
    nChecks++;
    if (outstate !== 3'b010) begin
      nFails++;
      $display("FAIL stop_held st=%b want 010", outstate);
    end
    drive(8'd21, 1'b0, 1'b0);
    e = sb.pop_front();
    last = outstate;
    for (int i = 0; i < 5; i++) begin
      drive(8'd40, 1'b0, 1'b0);
      e = sb.pop_front();
      got = {frame_cnt, acc_cnt, outstate, loadplat};
      nChecks++;
      if (got !== e) begin
        nFails++;
        $display("FAIL restart[%0d] got=%h want=%h", i, got, e);
      end
      if (loadplat === 1'b1) pulses++;
      if (last == 3'b000 && outstate == 3'b001) trans++;
      last = outstate;
    end
    nChecks++;
    if (pulses != 1 || trans != 1 || outstate !== 3'b001) begin
      nFails++;
      $display("FAIL restart_once pulses=%0d trans=%0d st=%b want 1/1/001",
               pulses, trans, outstate);
    end
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_count();
    test_clear_priority();
    test_start();
    test_play_stop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
